// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - shared state, ALU, NPC and opcode encodings for the multi-cycle control unit
package multi_cycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_e;

   localparam logic [3:0] ALU_NOP  = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SLLV = 6'h04;
   localparam logic [5:0] FUNCT_SRLV = 6'h06;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_SLTU = 6'h2B;

endpackage

// File: rtl/alu_op_dec.sv
// rtl/alu_op_dec.sv - combinational Op/Funct decode into EXE-stage ALU operation and operand selects
module alu_op_dec
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic [1:0] src_a,
   output logic [1:0] src_b,
   output logic       legal
);

   always_comb begin
      alu_op = ALU_NOP;
      src_a  = 2'b00;
      src_b  = 2'b00;
      legal  = 1'b1;
      case (op)
         OP_RTYPE: begin
            src_a = 2'b01;
            case (funct)
               FUNCT_ADD, FUNCT_ADDU: alu_op = ALU_ADD;
               FUNCT_SUB, FUNCT_SUBU: alu_op = ALU_SUB;
               FUNCT_AND:             alu_op = ALU_AND;
               FUNCT_OR:              alu_op = ALU_OR;
               FUNCT_NOR:             alu_op = ALU_NOR;
               FUNCT_SLT:             alu_op = ALU_SLT;
               FUNCT_SLTU:            alu_op = ALU_SLTU;
               FUNCT_SLLV:            alu_op = ALU_SLL;
               FUNCT_SRLV:            alu_op = ALU_SRL;
               // constant shifts take the shift amount from the instruction field
               FUNCT_SLL: begin alu_op = ALU_SLL; src_a = 2'b10; end
               FUNCT_SRL: begin alu_op = ALU_SRL; src_a = 2'b10; end
               default: begin
                  legal = 1'b0;
                  src_a = 2'b00;
               end
            endcase
         end
         OP_J, OP_JAL: begin
         end
         OP_BEQ, OP_BNE: begin
            src_a  = 2'b01;
            alu_op = ALU_SUB;
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
            src_b  = 2'b10;
            alu_op = ALU_ADD;
         end
         OP_SLTI: begin src_b = 2'b10; alu_op = ALU_SLT; end
         OP_ANDI: begin src_b = 2'b11; alu_op = ALU_AND; end
         OP_ORI:  begin src_b = 2'b11; alu_op = ALU_OR;  end
         OP_LUI:  begin src_b = 2'b11; alu_op = ALU_LUI; end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS control FSM sequencing IF/ID/EXE/MEM/WB with a MEM wait counter
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUOp,
   output logic [1:0] NPCOp,
   output logic [2:0] State,
   output logic       illegal_op
);

   localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);

   state_e     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic       pc_we, ir_we, rf_we, mem_we, ill;
   logic [3:0] dec_alu_op;
   logic [1:0] dec_src_a, dec_src_b;
   logic       dec_legal;
   logic       is_lw, is_sw;

   alu_op_dec u_dec (
      .op     (Op),
      .funct  (Funct),
      .alu_op (dec_alu_op),
      .src_a  (dec_src_a),
      .src_b  (dec_src_b),
      .legal  (dec_legal)
   );

   assign is_lw = (Op == OP_LW);
   assign is_sw = (Op == OP_SW);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IF;
         wait_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d  = S_IF;
      wait_d   = wait_q;
      pc_we    = 1'b0;
      ir_we    = 1'b0;
      rf_we    = 1'b0;
      mem_we   = 1'b0;
      ill      = 1'b0;
      RegDst   = 2'b00;
      MemtoReg = 2'b00;
      ALUSrcA  = 2'b00;
      ALUSrcB  = 2'b00;
      ALUOp    = ALU_NOP;
      NPCOp    = NPC_PLUS4;
      case (state_q)
         S_IF: begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            ALUSrcB = 2'b01;
            ALUOp   = ALU_ADD;
            state_d = S_ID;
         end
         S_ID: begin
            if (Op == OP_J || Op == OP_JAL) begin
               pc_we = 1'b1;
               NPCOp = NPC_JUMP;
               // jal links the already-incremented PC while the jump target loads
               if (Op == OP_JAL) begin
                  rf_we    = 1'b1;
                  RegDst   = 2'b10;
                  MemtoReg = 2'b10;
               end
            end else if (!dec_legal) begin
               ill = 1'b1;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            ALUOp   = dec_alu_op;
            ALUSrcA = dec_src_a;
            ALUSrcB = dec_src_b;
            if (Op == OP_BEQ || Op == OP_BNE) begin
               NPCOp = NPC_BRANCH;
               pc_we = (Op == OP_BEQ) ? Zero : ~Zero;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
               wait_d  = MEM_WAIT_C;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (wait_q == 4'd0) begin
               mem_we  = is_sw;
               state_d = is_lw ? S_WB : S_IF;
            end else begin
               wait_d  = wait_q - 4'd1;
               state_d = S_MEM;
            end
         end
         S_WB: begin
            rf_we = 1'b1;
            if (Op == OP_RTYPE) RegDst = 2'b01;
            if (is_lw)          MemtoReg = 2'b01;
         end
         default: state_d = S_IF;
      endcase
   end

   // reset masks every enable so an aborted instruction cannot commit a write
   assign PCWrite    = pc_we  & rstn;
   assign IRWrite    = ir_we  & rstn;
   assign RegWrite   = rf_we  & rstn;
   assign MemWrite   = mem_we & rstn;
   assign illegal_op = ill    & rstn;
   assign State      = state_q;

endmodule
